// File: rtl/mips_pipe_datapath.sv
// Five-stage MIPS-subset datapath with MEM/WB forwarding or full interlock, branch
// resolution in EX with flush, and a write-through register file.
module mips_pipe_datapath #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NREGS  = 32,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memtoreg_ID,
    input  logic             memwrite_ID,
    input  logic             alusrc_ID,
    input  logic             regdst_ID,
    input  logic             regwrite_ID,
    input  logic             branch_ID,
    input  logic [2:0]       alucontrol_ID,
    input  logic [31:0]      instr_if,
    input  logic [WIDTH-1:0] readdata,
    output logic [31:0]      pc,
    output logic [WIDTH-1:0] aluout_MEM,
    output logic [WIDTH-1:0] writedata,
    output logic             memwrite_MEM,
    output logic             stall,
    output logic             flush
);
    localparam int unsigned RW = $clog2(NREGS);

    logic             unused_opcode;
    logic [31:0]      instr_id, pc4_id;
    logic             valid_id;
    logic [RW-1:0]    rs_id, rt_id, rd_id;
    logic [WIDTH-1:0] imm_id, rd1_id, rd2_id;

    logic             memtoreg_ex, memwrite_ex, alusrc_ex, regdst_ex, regwrite_ex, branch_ex;
    logic [2:0]       aluctl_ex;
    logic [WIDTH-1:0] rd1_ex, rd2_ex, imm_ex;
    logic [RW-1:0]    rs_ex, rt_ex, rd_ex, dest_ex;
    logic [31:0]      pc4_ex, target_ex;
    logic [WIDTH-1:0] srca, fwdb, srcb, aluout_ex;

    logic             regwrite_mem, memtoreg_mem;
    logic [RW-1:0]    dest_mem;
    logic             regwrite_wb, memtoreg_wb;
    logic [RW-1:0]    dest_wb;
    logic [WIDTH-1:0] aluout_wb, readdata_wb, result_wb;

    logic [WIDTH-1:0] rf [NREGS];
    logic             hazard;

    assign unused_opcode = ^instr_id[31:26];
    assign rs_id  = instr_id[21 +: RW];
    assign rt_id  = instr_id[16 +: RW];
    assign rd_id  = instr_id[11 +: RW];
    assign imm_id = {{(WIDTH-16){instr_id[15]}}, instr_id[15:0]};
    assign result_wb = memtoreg_wb ? readdata_wb : aluout_wb;

    // Reads of the index being written back this cycle see the new value.
    always_comb begin
        rd1_id = '0;
        rd2_id = '0;
        if (rs_id != '0) rd1_id = (regwrite_wb && dest_wb == rs_id) ? result_wb : rf[rs_id];
        if (rt_id != '0) rd2_id = (regwrite_wb && dest_wb == rt_id) ? result_wb : rf[rt_id];
    end

    always_ff @(posedge clk) begin
        if (regwrite_wb && dest_wb != '0) rf[dest_wb] <= result_wb;
    end

    always_comb begin
        hazard = 1'b0;
        if (FWD_EN) begin
            hazard = memtoreg_ex && rt_ex != '0 && (rt_ex == rs_id || rt_ex == rt_id);
        end else begin
            hazard = (regwrite_ex && dest_ex != '0 && (dest_ex == rs_id || dest_ex == rt_id)) ||
                     (regwrite_mem && dest_mem != '0 && (dest_mem == rs_id || dest_mem == rt_id));
        end
    end

    assign flush = branch_ex && (aluout_ex == '0);
    assign stall = hazard && !flush;

    // Loads are excluded from MEM forwarding; their data is only available from WB.
    always_comb begin
        srca = rd1_ex;
        fwdb = rd2_ex;
        if (FWD_EN) begin
            if (regwrite_wb && dest_wb != '0 && dest_wb == rs_ex) srca = result_wb;
            if (regwrite_mem && !memtoreg_mem && dest_mem != '0 && dest_mem == rs_ex)
                srca = aluout_MEM;
            if (regwrite_wb && dest_wb != '0 && dest_wb == rt_ex) fwdb = result_wb;
            if (regwrite_mem && !memtoreg_mem && dest_mem != '0 && dest_mem == rt_ex)
                fwdb = aluout_MEM;
        end
    end

    assign srcb      = alusrc_ex ? imm_ex : fwdb;
    assign dest_ex   = regdst_ex ? rd_ex : rt_ex;
    assign target_ex = pc4_ex + {imm_ex[29:0], 2'b00};

    always_comb begin
        aluout_ex = '0;
        case (aluctl_ex)
            3'b010:  aluout_ex = srca + srcb;
            3'b110:  aluout_ex = srca - srcb;
            3'b000:  aluout_ex = srca & srcb;
            3'b001:  aluout_ex = srca | srcb;
            3'b111:  aluout_ex = {{(WIDTH-1){1'b0}}, $signed(srca) < $signed(srcb)};
            default: aluout_ex = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= '0;
            instr_id <= '0;
            pc4_id   <= '0;
            valid_id <= 1'b0;
        end else if (flush) begin
            pc       <= target_ex;
            instr_id <= '0;
            valid_id <= 1'b0;
        end else if (!stall) begin
            pc       <= pc + 32'd4;
            instr_id <= instr_if;
            pc4_id   <= pc + 32'd4;
            valid_id <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {memtoreg_ex, memwrite_ex, alusrc_ex, regdst_ex, regwrite_ex, branch_ex} <= '0;
            aluctl_ex <= '0;
            rd1_ex    <= '0;
            rd2_ex    <= '0;
            imm_ex    <= '0;
            rs_ex     <= '0;
            rt_ex     <= '0;
            rd_ex     <= '0;
            pc4_ex    <= '0;
        end else begin
            rd1_ex <= rd1_id;
            rd2_ex <= rd2_id;
            imm_ex <= imm_id;
            rs_ex  <= rs_id;
            rt_ex  <= rt_id;
            rd_ex  <= rd_id;
            pc4_ex <= pc4_id;
            if (flush || stall || !valid_id) begin
                {memtoreg_ex, memwrite_ex, alusrc_ex, regdst_ex, regwrite_ex, branch_ex} <= '0;
                aluctl_ex <= '0;
            end else begin
                memtoreg_ex <= memtoreg_ID;
                memwrite_ex <= memwrite_ID;
                alusrc_ex   <= alusrc_ID;
                regdst_ex   <= regdst_ID;
                regwrite_ex <= regwrite_ID;
                branch_ex   <= branch_ID;
                aluctl_ex   <= alucontrol_ID;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regwrite_mem <= 1'b0;
            memtoreg_mem <= 1'b0;
            memwrite_MEM <= 1'b0;
            aluout_MEM   <= '0;
            writedata    <= '0;
            dest_mem     <= '0;
            regwrite_wb  <= 1'b0;
            memtoreg_wb  <= 1'b0;
            aluout_wb    <= '0;
            readdata_wb  <= '0;
            dest_wb      <= '0;
        end else begin
            regwrite_mem <= regwrite_ex;
            memtoreg_mem <= memtoreg_ex;
            memwrite_MEM <= memwrite_ex;
            aluout_MEM   <= aluout_ex;
            writedata    <= fwdb;
            dest_mem     <= dest_ex;
            regwrite_wb  <= regwrite_mem;
            memtoreg_wb  <= memtoreg_mem;
            aluout_wb    <= aluout_MEM;
            readdata_wb  <= readdata;
            dest_wb      <= dest_mem;
        end
    end
endmodule

// File: tb/tb_mips_pipe_datapath.sv
// Directed bench: three datapath configurations, each with its own decoder model,
// instruction ROM and data memory; results observed through stores and aluout_MEM.
module tb_mips_pipe_datapath;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_SLT = 6'h2a;

    logic        clk = 1'b0;
    logic [2:0]  rst;
    logic [31:0] imem [3][32];
    logic [31:0] pc_o [3];
    logic [63:0] alu_o [3];
    logic [63:0] wd_o [3];
    logic [2:0]  mw_o, st_o, fl_o;
    int          n_stall [3];
    int          n_flush [3];
    int          n_store [3];
    logic [63:0] dmv [3][16];
    logic [31:0] prog [$];
    int          nvec = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    // Harness 0: 32-bit forwarding, 1: 32-bit interlock, 2: 64-bit / 16 registers.
    for (genvar g = 0; g < 3; g++) begin : h
        localparam int unsigned W  = (g == 2) ? 64 : 32;
        localparam int unsigned NR = (g == 2) ? 16 : 32;
        localparam bit          FW = (g != 1);

        logic [31:0]  instr_if, pc, instr_id;
        logic [W-1:0] readdata, aluout, wdata;
        logic         memwrite, stall, flush;
        logic         memtoreg_d, memwrite_d, alusrc_d, regdst_d, regwrite_d, branch_d;
        logic [2:0]   aluc_d;
        logic [63:0]  dmem [16];
        int           cnt_stall, cnt_flush, cnt_store;

        mips_pipe_datapath #(.WIDTH(W), .NREGS(NR), .FWD_EN(FW)) dut (
            .clk           (clk),
            .reset         (rst[g]),
            .memtoreg_ID   (memtoreg_d),
            .memwrite_ID   (memwrite_d),
            .alusrc_ID     (alusrc_d),
            .regdst_ID     (regdst_d),
            .regwrite_ID   (regwrite_d),
            .branch_ID     (branch_d),
            .alucontrol_ID (aluc_d),
            .instr_if      (instr_if),
            .readdata      (readdata),
            .pc            (pc),
            .aluout_MEM    (aluout),
            .writedata     (wdata),
            .memwrite_MEM  (memwrite),
            .stall         (stall),
            .flush         (flush)
        );

        assign instr_if = imem[g][pc[6:2]];
        assign readdata = W'(dmem[aluout[5:2]]);

        // Decoder's view of IF/ID, tracked from the DUT's pc/stall/flush ports.
        always_ff @(posedge clk) begin
            if (rst[g] || flush) instr_id <= '0;
            else if (!stall)     instr_id <= instr_if;
        end

        always_comb begin
            {memtoreg_d, memwrite_d, alusrc_d, regdst_d, regwrite_d, branch_d} = '0;
            aluc_d = 3'b000;
            case (instr_id[31:26])
                6'h00: if (instr_id[5:0] != 6'h00) begin
                    regdst_d   = 1'b1;
                    regwrite_d = 1'b1;
                    case (instr_id[5:0])
                        6'h20:   aluc_d = 3'b010;
                        6'h22:   aluc_d = 3'b110;
                        6'h24:   aluc_d = 3'b000;
                        6'h25:   aluc_d = 3'b001;
                        6'h2a:   aluc_d = 3'b111;
                        default: aluc_d = 3'b011;
                    endcase
                end
                OP_LW:   begin regwrite_d = 1'b1; alusrc_d = 1'b1; memtoreg_d = 1'b1; aluc_d = 3'b010; end
                OP_SW:   begin memwrite_d = 1'b1; alusrc_d = 1'b1; aluc_d = 3'b010; end
                OP_BEQ:  begin branch_d = 1'b1; aluc_d = 3'b110; end
                OP_ADDI: begin regwrite_d = 1'b1; alusrc_d = 1'b1; aluc_d = 3'b010; end
                default: ;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst[g]) begin
                cnt_stall <= 0;
                cnt_flush <= 0;
                cnt_store <= 0;
                for (int k = 0; k < 16; k++)
                    dmem[k] <= (k == 0) ? 64'd7 : 64'hDEAD_0000 + 64'(k);
            end else begin
                cnt_stall <= cnt_stall + (stall ? 1 : 0);
                cnt_flush <= cnt_flush + (flush ? 1 : 0);
                cnt_store <= cnt_store + (memwrite ? 1 : 0);
                if (memwrite) dmem[aluout[5:2]] <= 64'(wdata);
            end
        end

        assign pc_o[g]    = pc;
        assign alu_o[g]   = 64'(aluout);
        assign wd_o[g]    = 64'(wdata);
        assign mw_o[g]    = memwrite;
        assign st_o[g]    = stall;
        assign fl_o[g]    = flush;
        assign n_stall[g] = cnt_stall;
        assign n_flush[g] = cnt_flush;
        assign n_store[g] = cnt_store;
        for (genvar k = 0; k < 16; k++) begin : m
            assign dmv[g][k] = dmem[k];
        end
    end

    function automatic logic [31:0] rtype(int rs, int rt, int rd, logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(logic [5:0] op, int rs, int rt, logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds harness g in reset, loads prog, checks reset state, then releases at cycle 0.
    task automatic start(input int g);
        rst[g] = 1'b1;
        for (int i = 0; i < 32; i++) imem[g][i] = (i < prog.size()) ? prog[i] : 32'h0;
        step(2);
        check_eq("rst_pc", 64'(pc_o[g]), 64'd0);
        check_eq("rst_memwrite", 64'(mw_o[g]), 64'd0);
        check_eq("rst_aluout", alu_o[g], 64'd0);
        check_eq("rst_writedata", wd_o[g], 64'd0);
        check_eq("rst_stall_flush", {62'd0, st_o[g], fl_o[g]}, 64'd0);
        rst[g] = 1'b0;
    endtask

    initial begin
        rst = 3'b111;
        for (int g = 0; g < 3; g++)
            for (int i = 0; i < 32; i++) imem[g][i] = 32'h0;

        // Back-to-back forwarding chain.
        prog = '{itype(OP_ADDI, 0, 1, 16'd5), rtype(1, 1, 2, FN_ADD), rtype(2, 1, 3, FN_ADD),
                 itype(OP_SW, 0, 2, 16'd8), itype(OP_SW, 0, 3, 16'd12)};
        start(0);
        step(3); check_eq("fwd_addi_alu", alu_o[0], 64'd5);
        step(1); check_eq("fwd_add2_alu", alu_o[0], 64'd10);
        step(1); check_eq("fwd_add3_alu", alu_o[0], 64'd15);
        step(8);
        check_eq("fwd_mem2", dmv[0][2], 64'd10);
        check_eq("fwd_mem3", dmv[0][3], 64'd15);
        check_eq("fwd_no_stall", 64'(n_stall[0]), 64'd0);
        check_eq("fwd_stores", 64'(n_store[0]), 64'd2);

        // Load-use: one bubble, then WB forwarding.
        prog = '{itype(OP_LW, 0, 4, 16'd0), rtype(4, 4, 5, FN_ADD), itype(OP_SW, 0, 5, 16'd16)};
        start(0);
        step(2); check_eq("lu_stall_c2", 64'(st_o[0]), 64'd1);
        step(1); check_eq("lu_stall_c3", 64'(st_o[0]), 64'd0);
        step(2); check_eq("lu_add_alu", alu_o[0], 64'd14);
        step(8);
        check_eq("lu_mem4", dmv[0][4], 64'd14);
        check_eq("lu_stall_cnt", 64'(n_stall[0]), 64'd1);

        // Taken branch at pc 8 skips 0xC and 0x10.
        prog = '{itype(OP_ADDI, 0, 1, 16'd1), 32'h0, itype(OP_BEQ, 0, 0, 16'd2),
                 itype(OP_SW, 0, 1, 16'd20), itype(OP_ADDI, 0, 1, 16'd9),
                 itype(OP_SW, 0, 1, 16'd24)};
        start(0);
        step(3); check_eq("br_flush_c3", 64'(fl_o[0]), 64'd0);
        step(1); check_eq("br_flush_c4", 64'(fl_o[0]), 64'd1);
        check_eq("br_pc_c4", 64'(pc_o[0]), 64'h10);
        step(1); check_eq("br_pc_c5", 64'(pc_o[0]), 64'h14);
        check_eq("br_flush_c5", 64'(fl_o[0]), 64'd0);
        step(8);
        check_eq("br_mem6", dmv[0][6], 64'd1);
        check_eq("br_mem5_kept", dmv[0][5], 64'hDEAD_0005);
        check_eq("br_flush_cnt", 64'(n_flush[0]), 64'd1);
        check_eq("br_stores", 64'(n_store[0]), 64'd1);

        // Interlock without forwarding: two stall cycles.
        prog = '{itype(OP_ADDI, 0, 1, 16'd3), rtype(1, 1, 2, FN_ADD)};
        start(1);
        step(2); check_eq("il_stall_c2", 64'(st_o[1]), 64'd1);
        step(1); check_eq("il_stall_c3", 64'(st_o[1]), 64'd1);
        step(1); check_eq("il_stall_c4", 64'(st_o[1]), 64'd0);
        check_eq("il_pc_held", 64'(pc_o[1]), 64'h8);
        step(2); check_eq("il_add_alu", alu_o[1], 64'd6);
        step(6);
        check_eq("il_stall_cnt", 64'(n_stall[1]), 64'd2);
        check_eq("il_no_store", 64'(n_store[1]), 64'd0);

        // 64-bit, 16 registers: sub/slt, $0 writes dropped, register index truncation.
        prog = '{itype(OP_ADDI, 0, 1, 16'd1), rtype(0, 1, 2, FN_SUB), rtype(2, 0, 3, FN_SLT),
                 itype(OP_ADDI, 0, 0, 16'd5), itype(OP_SW, 0, 0, 16'd8),
                 itype(OP_SW, 0, 2, 16'd0), itype(OP_SW, 0, 3, 16'd4),
                 itype(OP_SW, 0, 17, 16'd12)};
        start(2);
        step(4); check_eq("w64_sub_alu", alu_o[2], 64'hFFFF_FFFF_FFFF_FFFF);
        step(1); check_eq("w64_slt_alu", alu_o[2], 64'd1);
        step(2); check_eq("w64_r0_addr", alu_o[2], 64'd8);
        check_eq("w64_r0_wdata", wd_o[2], 64'd0);
        step(7);
        check_eq("w64_mem0", dmv[2][0], 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("w64_mem1", dmv[2][1], 64'd1);
        check_eq("w64_mem2", dmv[2][2], 64'd0);
        check_eq("w64_alias", dmv[2][3], 64'd1);
        check_eq("w64_stores", 64'(n_store[2]), 64'd4);

        // Reset while a store sits in EX discards it.
        prog = '{itype(OP_ADDI, 0, 7, 16'd33), itype(OP_SW, 0, 7, 16'd28),
                 itype(OP_SW, 0, 7, 16'd32)};
        start(0);
        step(3);
        rst[0] = 1'b1;
        step(1);
        check_eq("mr_memwrite", 64'(mw_o[0]), 64'd0);
        check_eq("mr_pc", 64'(pc_o[0]), 64'd0);
        check_eq("mr_aluout", alu_o[0], 64'd0);
        step(1);
        check_eq("mr_memwrite_2", 64'(mw_o[0]), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
